dnn_act_requant: RTL and testbench

Activation stage directly downstream of the layer-1 MAC array. It captures the four 17-bit signed pre-activations when the MAC asserts its ready pulse, then applies ReLU, round-half-up right shift and saturation. The result is four 7-bit signed activations, presented to the layer-2 input under a valid/ready handshake. A single shared requantizer processes one lane per cycle.

---
 rtl/dnn_pkg.sv | 30 +++
 rtl/dnn_requant_lane.sv | 43 ++++
 rtl/dnn_act_requant.sv | 139 +++++++++++++
 tb/tb_dnn_act_requant.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_pkg.sv
// dnn_pkg
//   Types and constants shared by the layer-1 MAC, the activation
//   requantizer and the layer-2 input stage.
//   - IN_SIZE_DEF / OUT_SIZE_DEF : activation / pre-activation widths
//   - SHIFT_DEF                  : default requantization shift
//   - NUM_LANES                  : lanes handled by one requant pass
//   - ACT_MAX                    : saturation ceiling for IN_SIZE_DEF bits
//   - state_e                    : activation-stage FSM states
//   - act_max()                  : saturation ceiling for any width
package dnn_pkg;

  localparam int IN_SIZE_DEF  = 7;
  localparam int OUT_SIZE_DEF = 17;
  localparam int SHIFT_DEF    = 4;
  localparam int NUM_LANES    = 4;

  localparam int ACT_MAX = (2 ** (IN_SIZE_DEF - 1)) - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Largest positive value representable in a signed in_size-bit word.
  function automatic int act_max(input int in_size);
    return (1 << (in_size - 1)) - 1;
  endfunction

endpackage

// File: rtl/dnn_requant_lane.sv
// dnn_requant_lane
//   Combinational requantizer for one pre-activation:
//   ReLU -> round-half-up right shift by SHIFT -> saturate to the largest
//   positive IN_SIZE-bit value.
//   Ports:
//     x : in  signed [OUT_SIZE-1:0] pre-activation
//     a : out signed [IN_SIZE-1:0]  activation, always >= 0
module dnn_requant_lane
  import dnn_pkg::*;
#(
  parameter int IN_SIZE  = IN_SIZE_DEF,
  parameter int OUT_SIZE = OUT_SIZE_DEF,
  parameter int SHIFT    = SHIFT_DEF
) (
  input  logic signed [OUT_SIZE-1:0] x,
  output logic signed [IN_SIZE-1:0]  a
);

  // One extra bit so the rounding add of a full-scale positive value
  // cannot wrap.
  localparam int W = OUT_SIZE + 1;
  localparam logic [W-1:0] SAT = W'(act_max(IN_SIZE));

  logic [W-1:0] r;
  logic [W-1:0] t;

  // ReLU: negatives clamp to zero; positives zero-extend.
  assign r = x[OUT_SIZE-1] ? '0 : {1'b0, x};

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic [W-1:0] HALF = W'(1) << (SHIFT - 1);
      logic [W-1:0] sum;
      assign sum = r + HALF;
      assign t   = sum >> SHIFT;
    end else begin : g_pass
      assign t = r;
    end
  endgenerate

  assign a = (t > SAT) ? SAT[IN_SIZE-1:0] : t[IN_SIZE-1:0];

endmodule

// File: rtl/dnn_act_requant.sv
// dnn_act_requant
//   Activation stage behind the layer-1 MAC array. On mac_ready in IDLE
//   the four pre-activations are captured; a single shared requantizer
//   then writes one output lane per cycle (a4..a7 on the four following
//   edges) and the result is offered to layer 2 with act_valid/act_ready.
//   Ports:
//     clk, rst_n       : clock, async active-low reset
//     mac_ready        : capture request (in4..in7 valid when high)
//     in4..in7         : signed OUT_SIZE-bit pre-activations
//     act_valid        : a4..a7 hold a complete result
//     act_ready        : consumer accepts the result
//     a4..a7           : signed IN_SIZE-bit activations (>= 0)
//     busy             : high in PROC and HOLD
//     overrun          : sticky, a capture request was dropped
module dnn_act_requant
  import dnn_pkg::*;
#(
  parameter int IN_SIZE  = IN_SIZE_DEF,
  parameter int OUT_SIZE = OUT_SIZE_DEF,
  parameter int SHIFT    = SHIFT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mac_ready,
  input  logic signed [OUT_SIZE-1:0] in4,
  input  logic signed [OUT_SIZE-1:0] in5,
  input  logic signed [OUT_SIZE-1:0] in6,
  input  logic signed [OUT_SIZE-1:0] in7,
  output logic                       act_valid,
  input  logic                       act_ready,
  output logic signed [IN_SIZE-1:0]  a4,
  output logic signed [IN_SIZE-1:0]  a5,
  output logic signed [IN_SIZE-1:0]  a6,
  output logic signed [IN_SIZE-1:0]  a7,
  output logic                       busy,
  output logic                       overrun
);

  localparam int CW = $clog2(NUM_LANES);

  state_e                                state_q, state_d;
  logic [CW-1:0]                         lane_cnt_q, lane_cnt_d;
  logic [NUM_LANES-1:0][OUT_SIZE-1:0]    cap_q, cap_d;
  logic [NUM_LANES-1:0][IN_SIZE-1:0]     act_q, act_d;
  logic                                  valid_q, valid_d;
  logic                                  busy_q, busy_d;
  logic                                  ovr_q, ovr_d;

  logic signed [OUT_SIZE-1:0]            lane_x;
  logic signed [IN_SIZE-1:0]             lane_a;
  logic                                  capture;

  assign lane_x = cap_q[lane_cnt_q];

  dnn_requant_lane #(
    .IN_SIZE  (IN_SIZE),
    .OUT_SIZE (OUT_SIZE),
    .SHIFT    (SHIFT)
  ) u_lane (
    .x (lane_x),
    .a (lane_a)
  );

  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    cap_d      = cap_q;
    act_d      = act_q;
    ovr_d      = ovr_q;
    capture    = 1'b0;

    case (state_q)
      IDLE: begin
        if (mac_ready) begin
          capture = 1'b1;
          state_d = PROC;
        end
      end
      PROC: begin
        act_d[lane_cnt_q] = lane_a;
        lane_cnt_d        = lane_cnt_q + CW'(1);
        if (lane_cnt_q == CW'(NUM_LANES - 1)) state_d = HOLD;
        if (mac_ready) ovr_d = 1'b1;
      end
      HOLD: begin
        if (act_ready) begin
          // A request on the transfer edge is taken, not dropped.
          if (mac_ready) begin
            capture = 1'b1;
            state_d = PROC;
          end else begin
            state_d = IDLE;
          end
        end else if (mac_ready) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      cap_d      = {in7, in6, in5, in4};
      lane_cnt_d = '0;
    end

    // Status outputs are registered copies of the next state.
    valid_d = (state_d == HOLD);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lane_cnt_q <= '0;
      cap_q      <= '0;
      act_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      cap_q      <= cap_d;
      act_q      <= act_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
    end
  end

  assign act_valid = valid_q;
  assign busy      = busy_q;
  assign overrun   = ovr_q;
  assign a4        = act_q[0];
  assign a5        = act_q[1];
  assign a6        = act_q[2];
  assign a7        = act_q[3];

endmodule

// File: tb/tb_dnn_act_requant.sv
module tb_dnn_act_requant;

  localparam int IW = 7;
  localparam int OW = 17;
  localparam int SH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mac_ready = 1'b0;
  logic act_ready = 1'b0;
  logic signed [OW-1:0] in4 = '0, in5 = '0, in6 = '0, in7 = '0;
  logic act_valid, busy, overrun;
  logic signed [IW-1:0] a4, a5, a6, a7;

  dnn_act_requant #(.IN_SIZE(IW), .OUT_SIZE(OW), .SHIFT(SH)) dut (
    .clk(clk), .rst_n(rst_n), .mac_ready(mac_ready),
    .in4(in4), .in5(in5), .in6(in6), .in7(in7),
    .act_valid(act_valid), .act_ready(act_ready),
    .a4(a4), .a5(a5), .a6(a6), .a7(a7),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct { int x[4]; int e[4]; } vec_t;
  vec_t sb[$];
  vec_t tbl[8];
  vec_t mv;

  // Reference: ReLU, +8 then >>4 (SHIFT=4), clamp at 63.
  function automatic int model(input int x);
    int r, t;
    r = (x < 0) ? 0 : x;
    t = (r + 8) / 16;
    return (t > 63) ? 63 : t;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a capture request for one edge, then scramble the inputs so a
  // design that reads in4..in7 after capture is exposed.
  task automatic cap(input vec_t v);
    in4 = OW'(v.x[0]); in5 = OW'(v.x[1]); in6 = OW'(v.x[2]); in7 = OW'(v.x[3]);
    mac_ready = 1'b1;
    sb.push_back(v);
    step();
    mac_ready = 1'b0;
    in4 = OW'($urandom); in5 = OW'($urandom); in6 = OW'($urandom); in7 = OW'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!act_valid && lat < 20) begin
      step();
      lat++;
    end
    if (!act_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: act_valid still %0d after %0d cycles", act_valid, lat);
    end
  endtask

  task automatic accept();
    act_ready = 1'b1;
    step();
    act_ready = 1'b0;
    chk("valid_after_xfer", int'(act_valid), 0);
    chk("busy_after_xfer", int'(busy), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a4"}, int'(a4), 0);
    chk({tag, "_a5"}, int'(a5), 0);
    chk({tag, "_a6"}, int'(a6), 0);
    chk({tag, "_a7"}, int'(a7), 0);
    chk({tag, "_valid"}, int'(act_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    repeat (2) step();
    chk_zero("reset");
    rst_n = 1'b1;
    step();
  endtask

  // Scoreboard: a result is compared on the edge it is transferred.
  always @(negedge clk) begin
    if (rst_n && act_valid && act_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: transfer with no expected result queued");
      end else begin
        mv = sb.pop_front();
        chk("sb_a4", int'(a4), mv.e[0]);
        chk("sb_a5", int'(a5), mv.e[1]);
        chk("sb_a6", int'(a6), mv.e[2]);
        chk("sb_a7", int'(a7), mv.e[3]);
      end
    end
  end

  initial begin
    int lat;
    vec_t v2;

    tbl[0].x = '{100, -50, 20000, 8};      tbl[0].e = '{6, 0, 63, 1};
    tbl[1].x = '{7, 8, 23, 24};            tbl[1].e = '{0, 1, 1, 2};
    tbl[2].x = '{-65536, 65535, 999, 1000}; tbl[2].e = '{0, 63, 62, 63};
    tbl[3].x = '{0, -1, 40, 56};           tbl[3].e = '{0, 0, 3, 4};
    for (int i = 4; i < 8; i++) begin
      for (int l = 0; l < 4; l++) begin
        tbl[i].x[l] = (l < 2) ? int'($urandom_range(0, 1100)) - 100
                              : int'($urandom_range(0, 131071)) - 65536;
        tbl[i].e[l] = model(tbl[i].x[l]);
      end
    end

    do_reset();

    // Table vectors: latency 4 and scoreboard comparison on transfer.
    for (int i = 0; i < 8; i++) begin
      cap(tbl[i]);
      wait_valid(lat);
      chk("latency", lat, 4);
      chk("busy_hold", int'(busy), 1);
      accept();
    end

    // Backpressure: outputs hold for 10 cycles without act_ready.
    cap(tbl[0]);
    wait_valid(lat);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("bp_valid", int'(act_valid), 1);
      chk("bp_a4", int'(a4), tbl[0].e[0]);
      chk("bp_a6", int'(a6), tbl[0].e[2]);
      chk("bp_a7", int'(a7), tbl[0].e[3]);
    end
    accept();

    // Overrun in PROC: request at E2 is dropped.
    chk("ovr_init", int'(overrun), 0);
    cap(tbl[0]);
    step();
    in4 = 17'sd500; mac_ready = 1'b1;
    step();
    mac_ready = 1'b0;
    chk("ovr_proc", int'(overrun), 1);
    wait_valid(lat);
    chk("ovr_busy", int'(busy), 1);
    accept();
    repeat (3) step();
    chk("ovr_sticky", int'(overrun), 1);
    chk("ovr_idle_valid", int'(act_valid), 0);
    do_reset();

    // Overrun in HOLD without transfer.
    cap(tbl[1]);
    wait_valid(lat);
    in4 = 17'sd500; mac_ready = 1'b1;
    step();
    mac_ready = 1'b0;
    chk("ovr_hold", int'(overrun), 1);
    chk("ovr_hold_valid", int'(act_valid), 1);
    chk("ovr_hold_a4", int'(a4), tbl[1].e[0]);
    accept();
    do_reset();

    // Simultaneous transfer and capture.
    cap(tbl[0]);
    wait_valid(lat);
    v2.x = '{32, 0, 0, 0}; v2.e = '{2, 0, 0, 0};
    in4 = 17'sd32; in5 = '0; in6 = '0; in7 = '0;
    mac_ready = 1'b1; act_ready = 1'b1;
    sb.push_back(v2);
    step();
    mac_ready = 1'b0; act_ready = 1'b0;
    chk("simul_valid", int'(act_valid), 0);
    chk("simul_busy", int'(busy), 1);
    chk("simul_overrun", int'(overrun), 0);
    wait_valid(lat);
    chk("simul_latency", lat, 4);
    accept();
    chk("simul_overrun_end", int'(overrun), 0);

    // Async reset mid-PROC (with overrun set) between clock edges.
    cap(tbl[2]);
    mac_ready = 1'b1;
    step();
    mac_ready = 1'b0;
    chk("areset_pre_ovr", int'(overrun), 1);
    #3;
    rst_n = 1'b0;
    #2;
    chk_zero("areset");
    sb.delete();
    step();
    rst_n = 1'b1;
    step();
    cap(tbl[3]);
    wait_valid(lat);
    chk("areset_latency", lat, 4);
    accept();

    repeat (2) step();
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
